// File: rtl/vbsme_pkg.sv
// Shared VBSME constants and types: frame/window geometry, SAD and index widths, tracker state encoding.
package vbsme_pkg;

   localparam int FRAME_DIM = 64;
   localparam int WIN_DIM   = 4;
   localparam int SAD_W     = 12;
   localparam int IDX_W     = 6;
   localparam int LAST      = FRAME_DIM - WIN_DIM;

   localparam logic [SAD_W-1:0] SAD_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sad_stream_min_tracker_if.sv
// SAD stream from the SAD engine to the min tracker; valid/ready, one sample per handshake.
interface sad_stream_min_tracker_if
   import vbsme_pkg::*;
   ;

   logic [SAD_W-1:0] SadIn;
   logic             SadValid;
   logic             SadLast;
   logic             SadReady;

   modport master (output SadIn, output SadValid, output SadLast, input SadReady);
   modport slave  (input SadIn, input SadValid, input SadLast, output SadReady);

endinterface

// File: rtl/raster_pos_counter.sv
// Raster (i, j) position over 0..LAST in both axes; advances on adv, wraps to (0,0) after (LAST,LAST).
// Zero latency: at_last decodes the current position combinationally; no backpressure of its own.
module raster_pos_counter
   import vbsme_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j,
   output logic             at_last
);

   assign at_last = (i == LAST_IDX) && (j == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         i <= '0;
         j <= '0;
      end else if (adv) begin
         if (j == LAST_IDX) begin
            j <= '0;
            i <= at_last ? '0 : i + 1'b1;
         end else begin
            j <= j + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sad_stream_min_tracker.sv
// Streams one SAD per handshake in raster order and tracks the minimum and its (row, column).
// Done pulses the cycle after the final sample is accepted; SadReady is high only while scanning.
module sad_stream_min_tracker
   import vbsme_pkg::*;
(
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      Start,
   sad_stream_min_tracker_if.slave   s,
   output logic                      Busy,
   output logic                      Done,
   output logic [IDX_W-1:0]          MinI,
   output logic [IDX_W-1:0]          MinJ,
   output logic [SAD_W-1:0]          MinVal,
   output logic                      Error
);

   state_t           state;
   logic             first;
   logic             xfer;
   logic             at_last;
   logic [IDX_W-1:0] pos_i;
   logic [IDX_W-1:0] pos_j;

   assign s.SadReady = (state == SCAN);
   assign Busy       = (state == SCAN);
   assign xfer       = s.SadReady && s.SadValid;

   raster_pos_counter u_pos (
      .clk     (Clk),
      .rst     (Rst),
      .clr     ((state == IDLE) && Start),
      .adv     (xfer),
      .i       (pos_i),
      .j       (pos_j),
      .at_last (at_last)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         first  <= 1'b0;
         Done   <= 1'b0;
         Error  <= 1'b0;
         MinI   <= '0;
         MinJ   <= '0;
         MinVal <= SAD_MAX;
      end else begin
         Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Start) begin
                  state  <= SCAN;
                  first  <= 1'b1;
                  Error  <= 1'b0;
                  MinI   <= '0;
                  MinJ   <= '0;
                  MinVal <= SAD_MAX;
               end
            end
            SCAN: begin
               if (xfer) begin
                  first <= 1'b0;
                  // First sample always loads so an all-ones SAD at (0,0) is still reported
                  if (first || (s.SadIn < MinVal)) begin
                     MinVal <= s.SadIn;
                     MinI   <= pos_i;
                     MinJ   <= pos_j;
                  end
                  if (s.SadLast != at_last) begin
                     Error <= 1'b1;
                  end
                  if (at_last) begin
                     state <= DONE;
                     Done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
